// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a one-byte
// holding register with valid/ready handshake, frame error pulse and sticky overrun.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_good;
  logic             rx_meta;
  logic             rxs;
  logic             handshake;
  logic             accept;

  // Line synchronizer; idles high so reset cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rxs     <= rx_meta;
    end
  end

  // Frame FSM; byte_good is a one-cycle strobe that hands shreg to the holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_good <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      byte_good <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rxs) begin
              byte_good <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign handshake = rx_valid && rx_ready;
  assign accept    = byte_good && (!rx_valid || rx_ready);

  // Holding register: a byte arriving while the previous one is unconsumed is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (handshake) begin
        rx_valid <= 1'b0;
      end
      if (byte_good && !accept) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       reset;
  logic       UART_RX;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int   fe_cnt    = 0;
  int   rv_hi     = 0;
  int   rv_rise   = 0;
  int   busy_hi   = 0;
  logic rv_prev   = 1'b0;
  logic [7:0] rv_q[$];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters observed away from the active edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (rx_valid === 1'b1) rv_hi <= rv_hi + 1;
    if (rx_valid === 1'b1 && rv_prev !== 1'b1) begin
      rv_rise <= rv_rise + 1;
      rv_q.push_back(rx_data);
    end
    if (busy === 1'b1) busy_hi <= busy_hi + 1;
    rv_prev <= rx_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    UART_RX = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_latency();
    int lat;
    int fe0;
    lat = -1;
    fe0 = fe_cnt;
    rx_ready = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (rx_valid === 1'b1) begin
            lat = k;
            break;
          end
        end
      end
    join
    total++; if (lat != 155) begin bad++; $display("FAIL latency got=%0d want=155", lat); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL latency_data got=%h want=a5", rx_data); end
    total++; if (fe_cnt != fe0) begin bad++; $display("FAIL latency_frame_err got=%0d want=0", fe_cnt - fe0); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL latency_overrun got=%b want=0", overrun); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL latency_consume got=%b want=0", rx_valid); end
  endtask

  task automatic test_glitch();
    int b0, r0, f0;
    b0 = busy_hi; r0 = rv_rise; f0 = fe_cnt;
    UART_RX = 1'b0;
    wait_cycles(4);
    UART_RX = 1'b1;
    wait_cycles(30);
    total++; if ((busy_hi - b0) < 1 || (busy_hi - b0) > 10) begin bad++; $display("FAIL glitch_busy_cycles got=%0d want=1..10", busy_hi - b0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", busy); end
    total++; if (rv_rise != r0) begin bad++; $display("FAIL glitch_rx_valid got=%0d want=0", rv_rise - r0); end
    total++; if (fe_cnt != f0) begin bad++; $display("FAIL glitch_frame_err got=%0d want=0", fe_cnt - f0); end
  endtask

  task automatic test_frame_err();
    int r0, f0;
    logic [7:0] d;
    r0 = rv_rise; f0 = fe_cnt;
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    UART_RX = 1'b0;
    wait_cycles(40);
    total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL ferr_pulse_cycles got=%0d want=1", fe_cnt - f0); end
    total++; if (rv_rise != r0) begin bad++; $display("FAIL ferr_rx_valid got=%0d want=0", rv_rise - r0); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ferr_rx_valid_now got=%b want=0", rx_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_low_line got=%b want=1", busy); end
    UART_RX = 1'b1;
    wait_cycles(2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_high_plus1 got=%b want=1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_high_plus2 got=%b want=0", busy); end
    wait_cycles(4);
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL b2b_first_data got=%h want=11", rx_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_first_overrun got=%b want=0", overrun); end
    send_frame(8'h22, 1'b1);
    wait_cycles(4);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL b2b_data_held got=%h want=11", rx_data); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b want=1", overrun); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_clr_err got=%b want=0", overrun); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_after_clr got=%b want=1", rx_valid); end
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL b2b_data_after_clr got=%h want=11", rx_data); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_handshake got=%b want=0", rx_valid); end
  endtask

  task automatic test_reset_mid();
    int r0, f0;
    logic [7:0] d;
    d = 8'h5A;
    rx_ready = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    UART_RX = d[4];
    wait_cycles(CPB / 2);
    r0 = rv_rise; f0 = fe_cnt;
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midreset_rx_valid got=%b want=0", rx_valid); end
    reset = 1'b0;
    UART_RX = 1'b1;
    wait_cycles(40);
    total++; if (rv_rise != r0) begin bad++; $display("FAIL midreset_no_valid got=%0d want=0", rv_rise - r0); end
    total++; if (fe_cnt != f0) begin bad++; $display("FAIL midreset_no_ferr got=%0d want=0", fe_cnt - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_idle got=%b want=0", busy); end
    send_frame(8'h5A, 1'b1);
    wait_cycles(4);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL midreset_next_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL midreset_next_data got=%h want=5a", rx_data); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_stream();
    int r0, h0;
    r0 = rv_rise; h0 = rv_hi;
    rv_q.delete();
    rx_ready = 1'b1;
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_cycles(4);
    rx_ready = 1'b0;
    total++; if (rv_rise - r0 != 2) begin bad++; $display("FAIL stream_pulses got=%0d want=2", rv_rise - r0); end
    total++; if (rv_hi - h0 != 2) begin bad++; $display("FAIL stream_valid_cycles got=%0d want=2", rv_hi - h0); end
    total++; if (rv_q.size() < 1 || rv_q[0] !== 8'hFF) begin bad++; $display("FAIL stream_first got=%h want=ff", rv_q.size() > 0 ? rv_q[0] : 8'hxx); end
    total++; if (rv_q.size() < 2 || rv_q[1] !== 8'h00) begin bad++; $display("FAIL stream_second got=%h want=00", rv_q.size() > 1 ? rv_q[1] : 8'hxx); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL stream_overrun got=%b want=0", overrun); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    UART_RX  = 1'b1;
    rx_ready = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1042, clk cycles per bit (10 MHz / 9600 baud); SHALL be legal for any value >= 4.
REQ-002 clk  input  1  sole clock; all logic SHALL be rising-edge clk.
REQ-003 reset  input  1  synchronous, active-high; SHALL act only on a rising clk edge.
REQ-004 UART_RX  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-005 rx_data  output  8  last accepted byte.
REQ-006 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-008 frame_err  output  1  one-cycle pulse when the stop bit samples 0.
REQ-009 overrun  output  1  sticky; a good byte was dropped because the holding register was full.
REQ-010 clr_err  input  1  clears overrun.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 UART_RX SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions SHALL use the synchronized value rxs.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: rxs==0 SHALL clear the bit counter and enter START.
REQ-015 START: at counter == CLKS_PER_BIT/2-1 (integer division), the FSM SHALL sample rxs; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no output change).
REQ-016 DATA: rxs SHALL be sampled each time the counter reaches CLKS_PER_BIT-1 and shifted in LSB first; after the 8th sample the FSM SHALL enter STOP.
REQ-017 STOP: at counter == CLKS_PER_BIT-1, rxs==1 SHALL mark the byte good and enter IDLE; rxs==0 SHALL pulse frame_err for exactly one cycle, discard the byte, and enter WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL stay until rxs==1, then enter IDLE.
REQ-019 Good byte: if rx_valid==0, or rx_valid && rx_ready in the same cycle, rx_data SHALL load and rx_valid SHALL be 1 on the next cycle.
REQ-020 Good byte while rx_valid && !rx_ready: the byte SHALL be dropped, rx_data unchanged, overrun set to 1 on the next cycle.
REQ-021 rx_valid SHALL clear the cycle after rx_valid && rx_ready unless a new byte loads in that cycle.
REQ-022 rx_data SHALL stay stable while rx_valid==1 and no handshake occurs.
REQ-023 clr_err SHALL clear overrun on the next cycle; on a simultaneous set and clear, set SHALL win.
REQ-024 Bit counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL never wrap past CLKS_PER_BIT-1.
REQ-025 Latency: rx_valid SHALL rise exactly 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk cycles after the first clk edge that samples UART_RX low (for an immediately accepted byte).

Reset
REQ-026 On reset: FSM to IDLE, synchronizer flops 1, shift register 0, counter 0, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-027 Reset mid-frame SHALL abort the frame with no rx_valid or frame_err; reception SHALL restart only on a new falling edge seen after reset deasserts.

Verification (CLKS_PER_BIT = 16)
REQ-028 Frame 0xA5, rx_ready=0 -> rx_valid rises 155 cycles after UART_RX falls, rx_data=0xA5, frame_err=0, overrun=0.
REQ-029 UART_RX low for 4 cycles, then high -> busy high for at most 10 cycles, FSM returns to IDLE, no rx_valid, no frame_err.
REQ-030 Byte 0x3C with stop bit 0, line held low 40 cycles -> single-cycle frame_err, rx_valid stays 0, busy stays 1 until line high + 2 cycles.
REQ-031 Back-to-back 0x11, 0x22 with rx_ready=0 -> rx_data=0x11 held, overrun=1 after the 2nd stop; clr_err pulse -> overrun=0; handshake -> rx_valid=0.
REQ-032 Reset asserted during DATA bit 4 -> next cycle busy=0, rx_valid=0; following frame 0x5A received correctly.
REQ-033 rx_ready held 1, frames 0xFF then 0x00 -> two one-cycle rx_valid pulses carrying 0xFF then 0x00, overrun=0.
